regwrite_checker: RTL and testbench

Synthesizable, self-checking monitor that snoops the processor's register-file write port and compares each committed write, in order, against a programmable table of expected results. It replaces per-register polling in benches and on-board bring-up. It counts mismatches, flags a stalled pipeline via a watchdog, and reports pass/fail. It sits beside the regfile, on the same clock as the regfile write port.

---
 rtl/regwrite_checker_pkg.sv | 19 +
 rtl/regwrite_checker_check_table.sv | 39 +++
 rtl/regwrite_checker.sv | 145 ++++++++++++++
 tb/tb_regwrite_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regwrite_checker_pkg.sv
`default_nettype none
// ============================================================================
// regwrite_checker_pkg : shared state encoding and width helper
// Revision: 1.0
// ============================================================================
package regwrite_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regwrite_checker_check_table.sv
`default_nettype none
// ============================================================================
// check_table : expected {reg, data} table, synchronous write, async read
// Revision: 1.0
// ============================================================================
module check_table
  import regwrite_checker_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 16,
  localparam int IW            = idx_width(DEPTH)
) (
  input  logic                      clock,
  input  logic                      we,
  input  logic [IW-1:0]             waddr,
  input  logic [REG_ADDR_WIDTH-1:0] wreg,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [IW-1:0]             raddr,
  output logic [REG_ADDR_WIDTH-1:0] rreg,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [REG_ADDR_WIDTH-1:0] reg_q  [DEPTH];
  logic [DATA_WIDTH-1:0]     data_q [DEPTH];

  // Contents deliberately survive reset so a run can be repeated without reloading.
  always_ff @(posedge clock) begin
    if (we) begin
      reg_q[waddr]  <= wreg;
      data_q[waddr] <= wdata;
    end
  end

  assign rreg  = reg_q[raddr];
  assign rdata = data_q[raddr];

endmodule
`default_nettype wire

// File: rtl/regwrite_checker.sv
`default_nettype none
// ============================================================================
// regwrite_checker : compares snooped regfile writes against an expected table
// Revision: 1.0
// ============================================================================
module regwrite_checker
  import regwrite_checker_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT        = 64,
  parameter bit CHECK_REG      = 1'b1,
  parameter bit IGNORE_R0      = 1'b1,
  localparam int IW            = idx_width(DEPTH),
  localparam int CW            = IW + 1
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      load_en,
  input  logic [IW-1:0]             load_addr,
  input  logic [REG_ADDR_WIDTH-1:0] load_reg,
  input  logic [DATA_WIDTH-1:0]     load_data,
  input  logic [CW-1:0]             num_expected,
  input  logic                      start,
  input  logic                      mon_we,
  input  logic [REG_ADDR_WIDTH-1:0] mon_reg,
  input  logic [DATA_WIDTH-1:0]     mon_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [CW-1:0]             error_count,
  output logic                      mismatch_valid,
  output logic [IW-1:0]             mismatch_index,
  output logic [DATA_WIDTH-1:0]     mismatch_got
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_e                    state_q;
  logic [IW-1:0]             index_q;
  logic [CW-1:0]             count_q;
  logic [CW-1:0]             count_d;
  logic [WW-1:0]             wd_q;
  logic                      timeout_q;
  logic [CW-1:0]             err_q;
  logic                      mv_q;
  logic [IW-1:0]             mi_q;
  logic [DATA_WIDTH-1:0]     mg_q;

  logic [REG_ADDR_WIDTH-1:0] exp_reg;
  logic [DATA_WIDTH-1:0]     exp_data;
  logic                      table_we;
  logic                      qual;
  logic                      miss;
  logic                      last;

  assign table_we = ctrl_reset && load_en && (state_q == ST_IDLE);

  check_table #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .DEPTH          (DEPTH)
  ) u_table (
    .clock (clock),
    .we    (table_we),
    .waddr (load_addr),
    .wreg  (load_reg),
    .wdata (load_data),
    .raddr (index_q),
    .rreg  (exp_reg),
    .rdata (exp_data)
  );

  assign count_d = (num_expected > CW'(DEPTH)) ? CW'(DEPTH) : num_expected;
  assign qual    = mon_we && !(IGNORE_R0 && (mon_reg == '0));
  assign miss    = (mon_data != exp_data) || (CHECK_REG && (mon_reg != exp_reg));
  assign last    = ({1'b0, index_q} == (count_q - 1'b1));

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      count_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      mv_q      <= 1'b0;
      mi_q      <= '0;
      mg_q      <= '0;
    end else begin
      mv_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            index_q   <= '0;
            count_q   <= count_d;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            mi_q      <= '0;
            mg_q      <= '0;
          end
        end
        ST_RUN: begin
          if (count_q == '0) begin
            state_q <= ST_DONE;
          end else if (qual) begin
            index_q <= index_q + 1'b1;
            wd_q    <= '0;
            if (miss) begin
              err_q <= (err_q == '1) ? err_q : err_q + 1'b1;
              mv_q  <= 1'b1;
              mi_q  <= index_q;
              mg_q  <= mon_data;
            end
            if (last) begin
              state_q <= ST_DONE;
            end
          end else if (wd_q == WW'(TIMEOUT - 1)) begin
            // Error count is left as-is; the timeout flag alone forces a fail.
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (err_q == '0) && !timeout_q;
  assign timeout        = timeout_q;
  assign error_count    = err_q;
  assign mismatch_valid = mv_q;
  assign mismatch_index = mi_q;
  assign mismatch_got   = mg_q;

endmodule
`default_nettype wire

// File: tb/tb_regwrite_checker.sv
`default_nettype none
// ============================================================================
// tb_regwrite_checker : directed self-checking bench with mismatch scoreboard
// Revision: 1.0
// ============================================================================
module tb_regwrite_checker;

  logic        clock;
  logic        ctrl_reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [4:0]  load_reg;
  logic [31:0] load_data;
  logic [4:0]  num_expected;
  logic        start;
  logic        mon_we;
  logic [4:0]  mon_reg;
  logic [31:0] mon_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [4:0]  error_count;
  logic        mismatch_valid;
  logic [3:0]  mismatch_index;
  logic [31:0] mismatch_got;

  regwrite_checker dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_reg       (load_reg),
    .load_data      (load_data),
    .num_expected   (num_expected),
    .start          (start),
    .mon_we         (mon_we),
    .mon_reg        (mon_reg),
    .mon_data       (mon_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .error_count    (error_count),
    .mismatch_valid (mismatch_valid),
    .mismatch_index (mismatch_index),
    .mismatch_got   (mismatch_got)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] got;
  } miss_t;

  miss_t       exp_q[$];
  miss_t       mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [4:0]  m_reg  [16];
  logic [31:0] m_data [16];
  int          m_idx = 0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b0;
    step();
    ctrl_reset = 1'b1;
  endtask

  task automatic load(input int a, input logic [4:0] r, input logic [31:0] d);
    load_en = 1'b1; load_addr = a[3:0]; load_reg = r; load_data = d;
    m_reg[a] = r; m_data[a] = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic begin_run(input int n);
    num_expected = n[4:0]; start = 1'b1;
    step();
    start = 1'b0;
    m_idx = 0;
    m_cnt = (n > 16) ? 16 : n;
  endtask

  task automatic mon_write(input logic [4:0] r, input logic [31:0] d);
    mon_we = 1'b1; mon_reg = r; mon_data = d;
    if (r != 5'd0 && m_idx < m_cnt) begin
      if (d != m_data[m_idx] || r != m_reg[m_idx])
        exp_q.push_back('{idx: m_idx[3:0], got: d});
      m_idx++;
    end
    step();
    mon_we = 1'b0;
  endtask

  // Scoreboard: every mismatch pulse must match the oldest predicted mismatch.
  always @(negedge clock) begin
    if (mismatch_valid === 1'b1) begin
      chk("mm_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("mm_index", mismatch_index, mon_e.idx);
        chk("mm_got", mismatch_got, mon_e.got);
      end
    end
  end

  initial begin
    ctrl_reset = 1'b0; load_en = 1'b0; load_addr = '0; load_reg = '0; load_data = '0;
    num_expected = '0; start = 1'b0; mon_we = 1'b0; mon_reg = '0; mon_data = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", error_count, 0);
    chk("rst_mv", mismatch_valid, 0);
    ctrl_reset = 1'b1;

    // 1: three matching writes
    load(0, 5'd1, 32'd65535);
    load(1, 5'd2, 32'd2147450880);
    load(2, 5'd3, 32'd2147483647);
    begin_run(3);
    chk("t1_busy", busy, 1);
    mon_write(5'd1, 32'd65535);
    mon_write(5'd2, 32'd2147450880);
    chk("t1_not_done_early", done, 0);
    mon_write(5'd3, 32'd2147483647);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_err", error_count, 0);
    step();
    chk("t1_pending", exp_q.size(), 0);

    // 2: second write corrupted
    begin_run(3);
    mon_write(5'd1, 32'd65535);
    mon_write(5'd2, 32'd2147450881);
    mon_write(5'd3, 32'd2147483647);
    chk("t2_done", done, 1);
    chk("t2_err", error_count, 1);
    chk("t2_pass", pass, 0);
    step();
    chk("t2_hold_index", mismatch_index, 1);
    chk("t2_hold_got", mismatch_got, 32'd2147450881);
    chk("t2_pending", exp_q.size(), 0);

    // 3: wrong destination register, r0 write ignored, load ignored in RUN
    do_reset();
    load(0, 5'd13, 32'hFFFF_FFFF);
    load(1, 5'd5, 32'h0000_1234);
    begin_run(2);
    mon_write(5'd14, 32'hFFFF_FFFF);
    load_en = 1'b1; load_addr = 4'd1; load_reg = 5'd7; load_data = 32'hDEAD_BEEF;
    mon_write(5'd0, 32'h5555_5555);
    load_en = 1'b0;
    chk("t3_still_busy", busy, 1);
    mon_write(5'd5, 32'h0000_1234);
    chk("t3_done", done, 1);
    chk("t3_err", error_count, 1);
    chk("t3_pass", pass, 0);
    step();
    chk("t3_pending", exp_q.size(), 0);

    // 4: watchdog
    begin_run(2);
    mon_write(5'd13, 32'hFFFF_FFFF);
    for (int i = 0; i < 63; i++) step();
    chk("t4_busy_63", busy, 1);
    chk("t4_timeout_63", timeout, 0);
    step();
    chk("t4_done_64", done, 1);
    chk("t4_timeout_64", timeout, 1);
    chk("t4_pass", pass, 0);
    chk("t4_err", error_count, 0);
    begin_run(2);
    chk("t4_timeout_cleared", timeout, 0);

    // 5: reset mid-run, then rerun on the retained table
    do_reset();
    load(0, 5'd1, 32'd65535);
    load(1, 5'd2, 32'd2147450880);
    load(2, 5'd3, 32'd2147483647);
    begin_run(3);
    mon_write(5'd1, 32'd65535);
    do_reset();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_pass", pass, 0);
    chk("t5_err", error_count, 0);
    chk("t5_mv", mismatch_valid, 0);
    begin_run(3);
    mon_write(5'd1, 32'd65535);
    mon_write(5'd2, 32'd2147450880);
    mon_write(5'd3, 32'd2147483647);
    chk("t5_rerun_pass", pass, 1);

    // 6: zero count and clamped oversize count
    begin_run(0);
    chk("t6_zero_busy", busy, 1);
    step();
    chk("t6_zero_done", done, 1);
    chk("t6_zero_pass", pass, 1);
    do_reset();
    for (int i = 0; i < 16; i++) load(i, 5'(i + 1), $urandom);
    begin_run(21);
    for (int i = 0; i < 15; i++) mon_write(m_reg[i], m_data[i]);
    chk("t6_clamp_busy", busy, 1);
    mon_write(m_reg[15], m_data[15]);
    chk("t6_clamp_done", done, 1);
    chk("t6_clamp_pass", pass, 1);
    step();
    chk("t6_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
